// File: rtl/pmod_jstk_paddle.sv
// PmodJSTK SPI master (mode 0, 5-byte poll per frame) that turns the joystick Y
// reading into a clamped paddle position moving at most STEP pixels per frame.
module pmod_jstk_paddle #(
    parameter int SCK_HALF = 25,
    parameter int CS_SETUP = 750,
    parameter int BYTE_GAP = 500,
    parameter int DEAD_LO  = 400,
    parameter int DEAD_HI  = 624,
    parameter int STEP     = 4,
    parameter int Y_MAX    = 430
) (
    input  logic       clk50M,
    input  logic       reset_n,
    input  logic       endofframe,
    output logic       cs,
    output logic       mosi,
    input  logic       miso,
    output logic       sck,
    output logic [9:0] y,
    output logic       isMoving,
    output logic [9:0] joy_y,
    output logic       sample_valid
);

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_GAP, ST_DONE} state_t;

    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] GAP_LAST   = 16'(BYTE_GAP - 1);
    localparam logic [15:0] SAMPLE_CNT = 16'(SCK_HALF - 1);
    localparam logic [15:0] BIT_LAST   = 16'(2 * SCK_HALF - 1);
    localparam logic [15:0] HALF_CNT   = 16'(SCK_HALF);
    localparam logic [9:0]  DLO        = 10'(DEAD_LO);
    localparam logic [9:0]  DHI        = 10'(DEAD_HI);
    localparam logic [9:0]  STP        = 10'(STEP);
    localparam logic [9:0]  YMAX       = 10'(Y_MAX);
    localparam logic [9:0]  YTOP_LIM   = 10'(Y_MAX - STEP);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d, byte_q, byte_d;
    logic [7:0]  shreg_q, shreg_d, byte2_q, byte2_d;
    logic [1:0]  byte3_q, byte3_d;
    logic        eof_q;
    logic        start_s;
    logic        cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d;
    logic [9:0]  y_q, y_d, joy_q, joy_d, y_next_s;
    logic        mov_q, mov_d, valid_q, valid_d;
    logic [7:0]  tx_s;

    assign start_s = endofframe & ~eof_q;

    // Candidate paddle position from the currently held joystick reading
    always_comb begin
        y_next_s = y_q;
        if (joy_q > DHI) begin
            y_next_s = (y_q < STP) ? 10'd0 : y_q - STP;
        end else if (joy_q < DLO) begin
            y_next_s = (y_q > YTOP_LIM) ? YMAX : y_q + STP;
        end else begin
            y_next_s = y_q;
        end
    end

    // Transaction sequencing, shifting, capture and paddle update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        byte2_d = byte2_q;
        byte3_d = byte3_q;
        y_d     = y_q;
        mov_d   = mov_q;
        joy_d   = joy_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    y_d     = y_next_s;
                    mov_d   = (y_next_s != y_q);
                    cnt_d   = 16'd0;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = 16'd0;
                    bit_d   = 3'd7;
                    byte_d  = 3'd0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = 16'd0;
                    if (bit_q == 3'd0) begin
                        // Only bytes 2 and 3 carry the Y reading
                        if (byte_q == 3'd2) begin
                            byte2_d = shreg_q;
                        end else if (byte_q == 3'd3) begin
                            byte3_d = shreg_q[1:0];
                        end else begin
                            byte2_d = byte2_q;
                        end
                        state_d = (byte_q < 3'd4) ? ST_GAP : ST_DONE;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == SAMPLE_CNT) begin
                        shreg_d = {shreg_q[6:0], miso};
                    end else begin
                        shreg_d = shreg_q;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 16'd0;
                    bit_d   = 3'd7;
                    byte_d  = byte_q + 3'd1;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                joy_d   = {byte3_q, byte2_q};
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SPI pins derived from the next state so they leave the flops glitch-free
    always_comb begin
        tx_s   = (byte_d == 3'd0) ? 8'h80 : 8'h00;
        cs_d   = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_GAP));
        sck_d  = (state_d == ST_SHIFT) && (cnt_d >= HALF_CNT);
        mosi_d = (state_d == ST_SHIFT) ? tx_s[bit_d] : 1'b0;
    end

    // State and output registers
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd7;
            byte_q  <= 3'd0;
            shreg_q <= 8'h00;
            byte2_q <= 8'h00;
            byte3_q <= 2'b00;
            eof_q   <= 1'b0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            y_q     <= 10'd215;
            mov_q   <= 1'b0;
            joy_q   <= 10'd512;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            byte2_q <= byte2_d;
            byte3_q <= byte3_d;
            eof_q   <= endofframe;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            y_q     <= y_d;
            mov_q   <= mov_d;
            joy_q   <= joy_d;
            valid_q <= valid_d;
        end
    end

    assign cs           = cs_q;
    assign sck          = sck_q;
    assign mosi         = mosi_q;
    assign y            = y_q;
    assign isMoving     = mov_q;
    assign joy_y        = joy_q;
    assign sample_valid = valid_q;

endmodule
